// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, response type and a response classifier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   // Anything other than OKAY is reported to the core as an error; AXI-lite
   // has no exclusive access, so EXOKAY is treated as a failure too.
   function automatic logic resp_is_err(input resp_t resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle with master and slave views.
// Latency: n/a (wiring only).
// Backpressure: standard per-channel valid/ready.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import axi_lite_pkg::*;

   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    bvalid;
   logic                    bready;
   resp_t                   bresp;
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   resp_t                   rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// Converts single-outstanding core load/store requests into AXI-lite master transactions.
// Latency: 3 cycles from request acceptance to resp_valid against a zero-wait slave.
// Backpressure: req_ready only in IDLE; AXI valids held until handshake; response pulse is not backpressured.
// Ports: clk, rst (synchronous, active-high); req_* core request; resp_valid/resp_rdata/resp_err
//        one-cycle completion with held data/error; m_axi AXI-lite master port.
module axi_lite_master_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   axi_lite_if.master              m_axi
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP} state_e;

   state_e                  state_q, state_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic                    aw_hs, w_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      resp_valid_d  = 1'b0;
      rdata_d       = rdata_q;
      err_d         = err_q;
      aw_hs         = 1'b0;
      w_hs          = 1'b0;
      req_ready     = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.bready  = 1'b0;
      // Payloads come straight from the request register, so they are stable
      // for as long as any valid is up.
      m_axi.araddr  = addr_q;
      m_axi.arprot  = 3'b000;
      m_axi.awaddr  = addr_q;
      m_axi.awprot  = 3'b000;
      m_axi.wdata   = wdata_q;
      m_axi.wstrb   = wstrb_q;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               state_d = req_we ? WRITE : RADDR;
            end
         end
         RADDR: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) state_d = RDATA;
         end
         RDATA: begin
            m_axi.rready = 1'b1;
            if (m_axi.rvalid) begin
               err_d        = resp_is_err(m_axi.rresp);
               resp_valid_d = 1'b1;
               state_d      = IDLE;
            end
         end
         WRITE: begin
            // AW and W retire independently; the handshake in the current
            // cycle counts, so a slave taking both at once costs no extra cycle.
            m_axi.awvalid = !aw_done_q;
            m_axi.wvalid  = !w_done_q;
            aw_hs         = !aw_done_q && m_axi.awready;
            w_hs          = !w_done_q && m_axi.wready;
            aw_done_d     = aw_done_q || aw_hs;
            w_done_d      = w_done_q || w_hs;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WRESP;
            end
         end
         WRESP: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) begin
               err_d        = resp_is_err(m_axi.bresp);
               resp_valid_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Single capture point for returned data: stores report zero.
      if (resp_valid_d) rdata_d = we_q ? '0 : m_axi.rdata;
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
module tb_axi_lite_master_bridge;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   int n_tests, n_fail;

   // slave state and instrumentation
   int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
   bit          r_pend, aw_got, w_got, b_pend, slv_err;
   logic [31:0] r_addr, aw_addr_s, w_data_s;
   logic [3:0]  w_strb_s;
   int          b_cnt, w_first_cycles, order_viol;

   logic [31:0] slv_mem [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];

   always #5 clk = ~clk;

   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

   axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_axi(axi)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
   endfunction

   function automatic int rnd_wait(input int maxw);
      return (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
   endfunction

   // Behavioural AXI-lite RAM slave. Decisions are made at the falling edge; a
   // ready/valid pair set here completes at the following rising edge.
   task automatic slave_loop();
      forever begin
         @(negedge clk);
         if (rst) begin
            axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            axi.rdata = 0; axi.rresp = RESP_OKAY; axi.bresp = RESP_OKAY;
            r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
         end else begin
            if (w_got && !aw_got) begin
               w_first_cycles++;
               if (axi.wvalid || !axi.awvalid) order_viol++;
            end
            axi.rvalid = 0;
            if (r_pend) begin
               if (r_wait == 0) begin
                  axi.rvalid = 1; axi.rdata = slv_rd(r_addr);
                  axi.rresp = slv_err ? RESP_SLVERR : RESP_OKAY;
               end else r_wait--;
            end
            if (axi.rvalid && axi.rready) r_pend = 0;
            axi.arready = 0;
            if (axi.arvalid && !r_pend) begin
               if (ar_wait == 0) axi.arready = 1; else ar_wait--;
            end
            if (axi.arvalid && axi.arready) begin r_pend = 1; r_addr = axi.araddr; end
            axi.bvalid = 0;
            if (b_pend) begin
               if (b_wait == 0) begin
                  axi.bvalid = 1; axi.bresp = slv_err ? RESP_SLVERR : RESP_OKAY;
               end else b_wait--;
            end
            if (axi.bvalid && axi.bready) begin b_pend = 0; b_cnt++; end
            axi.awready = 0;
            if (axi.awvalid && !aw_got && !b_pend) begin
               if (aw_wait == 0) axi.awready = 1; else aw_wait--;
            end
            if (axi.awvalid && axi.awready) begin aw_got = 1; aw_addr_s = axi.awaddr; end
            axi.wready = 0;
            if (axi.wvalid && !w_got && !b_pend) begin
               if (w_wait == 0) axi.wready = 1; else w_wait--;
            end
            if (axi.wvalid && axi.wready) begin w_got = 1; w_data_s = axi.wdata; w_strb_s = axi.wstrb; end
            if (aw_got && w_got) begin
               if (!slv_err) slv_mem[aw_addr_s[31:2]] = merge(slv_rd(aw_addr_s), w_data_s, w_strb_s);
               aw_got = 0; w_got = 0; b_pend = 1;
            end
         end
      end
   endtask

   task automatic set_waits(input int maxw);
      ar_wait = rnd_wait(maxw); r_wait = rnd_wait(maxw);
      aw_wait = rnd_wait(maxw); w_wait = rnd_wait(maxw); b_wait = rnd_wait(maxw);
   endtask

   // Issues one request (called at a falling edge) and checks its response.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit err, input int exp_lat, input string name);
      logic [31:0] exp_rdata;
      int n, lat;
      if (we) begin
         exp_rdata = 32'h0;
         if (!err) ref_mem[addr[31:2]] = merge(ref_rd(addr), wdata, strb);
      end else exp_rdata = ref_rd(addr);
      slv_err = err;
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
      n_tests++;
      if (resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: resp_valid=%b after %0d cycles, required 1", name, resp_valid, lat);
      end else begin
         n_tests++;
         if (resp_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s rdata: got %h required %h", name, resp_rdata, exp_rdata);
         end
         n_tests++;
         if (resp_err !== err) begin
            n_fail++; $display("FAIL %s err: got %b required %b", name, resp_err, err);
         end
         if (exp_lat > 0) begin
            n_tests++;
            if (lat != exp_lat) begin
               n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
            end
         end
         @(negedge clk);
         n_tests++;
         if (resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s pulse width: resp_valid=%b one cycle later, required 0", name, resp_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, resp_valid, resp_err} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset outputs: ar/aw/w/r/b/resp_valid/err=%b required 0000000",
                  {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, resp_valid, resp_err});
      end
      n_tests++;
      if (resp_rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset rdata: got %h required 0", resp_rdata);
      end
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset req_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_load();
      set_waits(0);
      do_req(0, 32'h8000_0010, 32'h0, 4'h0, 0, 3, "load");
      n_tests++;
      if (resp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL load preload: got %h required deadbeef", resp_rdata);
      end
   endtask

   task automatic test_store_load();
      set_waits(0);
      do_req(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0, 3, "store");
      do_req(0, 32'h8000_0020, 32'h0, 4'h0, 0, 3, "store_load");
      n_tests++;
      if (resp_rdata !== 32'h1234_5678) begin
         n_fail++; $display("FAIL store_load data: got %h required 12345678", resp_rdata);
      end
   endtask

   task automatic test_partial_store();
      set_waits(0);
      do_req(1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0010, 0, 3, "partial_store");
      do_req(0, 32'h8000_0020, 32'h0, 4'h0, 0, 3, "partial_load");
      n_tests++;
      if (resp_rdata !== 32'h1234_CC78) begin
         n_fail++; $display("FAIL partial merge: got %h required 1234cc78", resp_rdata);
      end
   endtask

   task automatic test_error();
      set_waits(1);
      do_req(1, 32'h8000_0024, 32'h5555_AAAA, 4'hF, 1, 0, "err_store");
      set_waits(1);
      do_req(0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, "err_clear_load");
   endtask

   task automatic test_w_before_aw();
      int b0, wf0, ov0;
      set_waits(0);
      aw_wait = 2; w_wait = 0;
      b0 = b_cnt; wf0 = w_first_cycles; ov0 = order_viol;
      do_req(1, 32'h8000_0028, 32'hCAFE_F00D, 4'hF, 0, 0, "w_first_store");
      n_tests++;
      if (b_cnt - b0 != 1) begin
         n_fail++; $display("FAIL w_first b count: got %0d required 1", b_cnt - b0);
      end
      n_tests++;
      if (w_first_cycles - wf0 != 2) begin
         n_fail++; $display("FAIL w_first window: got %0d cycles required 2", w_first_cycles - wf0);
      end
      n_tests++;
      if (order_viol != ov0) begin
         n_fail++; $display("FAIL w_first valids: %0d cycles with wvalid high or awvalid low, required 0", order_viol - ov0);
      end
      set_waits(0);
      aw_wait = 0; w_wait = 2;
      do_req(1, 32'h8000_002C, 32'h0BAD_F00D, 4'b1100, 0, 0, "aw_first_store");
      set_waits(0);
      do_req(0, 32'h8000_0028, 32'h0, 4'h0, 0, 3, "w_first_load");
   endtask

   task automatic test_reset_mid();
      int n, pulses;
      set_waits(0);
      ar_wait = 1000; slv_err = 0;
      req_valid = 1; req_we = 0; req_addr = 32'h8000_0010;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 0;
      n_tests++;
      if (axi.arvalid !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid pre arvalid: got %b required 1", axi.arvalid);
      end
      rst = 1;
      @(negedge clk);
      n_tests++;
      if (axi.arvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid arvalid: got %b required 0", axi.arvalid);
      end
      pulses = resp_valid ? 1 : 0;
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid req_ready: got %b required 1", req_ready);
      end
      repeat (5) begin
         if (resp_valid) pulses++;
         @(negedge clk);
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL reset_mid resp pulses: got %0d required 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp1, exp2;
      int n, lat;
      set_waits(0); slv_err = 0;
      exp1 = ref_rd(32'h8000_0010);
      exp2 = ref_rd(32'h8000_0020);
      req_valid = 1; req_we = 0; req_addr = 32'h8000_0010;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_addr = 32'h8000_0020;
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp1) begin
         n_fail++; $display("FAIL b2b first: valid=%b rdata=%h required 1/%h", resp_valid, resp_rdata, exp1);
      end
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b accept in resp cycle: req_ready=%b required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp2) begin
         n_fail++; $display("FAIL b2b second: valid=%b rdata=%h required 1/%h", resp_valid, resp_rdata, exp2);
      end
      n_tests++;
      if (lat != 3) begin
         n_fail++; $display("FAIL b2b second latency: got %0d required 3", lat);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic we;
      for (int i = 0; i < 40; i++) begin
         set_waits(3);
         a  = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4;
         d  = $urandom;
         we = $urandom_range(0, 1) == 1;
         do_req(we, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, 0, "random");
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      slv_err = 0; b_cnt = 0; w_first_cycles = 0; order_viol = 0;
      r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      slv_mem[30'h2000_0004] = 32'hDEAD_BEEF;
      ref_mem[30'h2000_0004] = 32'hDEAD_BEEF;
      fork
         slave_loop();
      join_none
      test_reset();
      test_load();
      test_store_load();
      test_partial_store();
      test_error();
      test_w_before_aw();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- Converts the core's single-outstanding load/store request interface into AXI-lite master transactions.
- Sits directly upstream of the AXI-lite RAM and any other AXI-lite slave on the data or instruction path.
- Handles one transaction at a time: latches the request, drives AR/R or AW/W/B, then returns one response pulse to the core.

Parameters:
- ADDR_WIDTH, 32: width of the request address and of araddr/awaddr.
- DATA_WIDTH, 32: width of the data bus; wstrb width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- req_valid  input  1  core request present.
- req_ready  output  1  bridge can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- req_wstrb  input  DATA_WIDTH/8  store byte enables.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  load data, valid with resp_valid; 0 for stores.
- resp_err  output  1  slave returned a non-OKAY rresp/bresp.
- m_axi  interface  -  axi_lite_if.master port to the downstream slave.

Behaviour:
Reset (rst high at a clk edge):
- State goes to IDLE.
- arvalid, awvalid, wvalid, rready, bready, resp_valid and resp_err are 0; resp_rdata is 0.
- req_ready is 1 from the first cycle after reset.

States: IDLE, RADDR, RDATA, WRITE, WRESP.

IDLE:
- req_ready = 1.
- On req_valid, latch addr, we, wdata and wstrb into registers.
- Next state is RADDR if we = 0, else WRITE.

RADDR:
- arvalid = 1 and araddr = latched addr; arprot = 0.
- Hold arvalid and araddr stable until arvalid && arready, then go to RDATA.

RDATA:
- rready = 1.
- On rvalid, capture rdata and set err = (rresp != RESP_OKAY).
- Go to IDLE and pulse resp_valid in the following cycle.

WRITE:
- awvalid and wvalid are both asserted on entry.
- Each is dropped independently after its own handshake, tracked by aw_done and w_done flags.
- Slaves that accept AW before W (zero-cycle overlap) and slaves that accept both together must both work.
- When both flags are set, clear the flags and go to WRESP.
- awaddr, wdata and wstrb stay stable while their valid is high.

WRESP:
- bready = 1.
- On bvalid, set err = (bresp != RESP_OKAY), go to IDLE and pulse resp_valid.

Response timing:
- resp_valid is registered and high for exactly one cycle, in the cycle after the R or B handshake.
- resp_rdata and resp_err hold their values until the next response; they are not cleared.
- There is no backpressure on the response; the core must sample it.

Request timing:
- A new request can be accepted in the same cycle resp_valid is high, because the state is already IDLE.
- Minimum latency against a slave that responds at once is 3 cycles from request acceptance to resp_valid.

Boundary conditions:
- Address is passed through unmodified; the bridge does no alignment checking.
- req_valid seen outside IDLE is ignored; req_ready = 0 there.
- Reset in any state aborts immediately: all valids drop in the next cycle. The slave must be reset on the same cycle.
- An X-free rdata is not required unless rvalid is high.

Decomposition:
- Use the shared axi_lite_pkg for RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR and the resp typedef.
- The state enum stays local to the module.
- No sub-module: a single FSM plus a request register and the two done flags.

Test Plan:
- Load: ram slave at START_ADDR 0x80000000 preloaded with word 0xDEADBEEF at 0x80000010; load 0x80000010 -> one resp_valid pulse, resp_rdata = 0xDEADBEEF, resp_err = 0.
- Store then load: store 0x12345678 with wstrb 4'b1111 at 0x80000020 -> resp_valid with err = 0; a following load returns 0x12345678.
- Partial store: store 0xAABBCCDD with wstrb 4'b0010 over 0x12345678 -> a following load returns 0x1234CC78.
- Error response: stub slave returns bresp = SLVERR -> resp_err = 1; the next load returning OKAY -> resp_err = 0.
- W before AW: stub slave accepts W 2 cycles before AW -> wvalid drops after the W handshake, awvalid holds until accepted, exactly one B is consumed.
- Reset mid-transaction: assert rst while in RADDR with arready held low -> arvalid = 0 in the next cycle, req_ready = 1 after reset is released, no resp_valid pulse.
- Back-to-back: a second req_valid held high through the first response -> accepted in the resp_valid cycle; 2 responses in order, no lost request.
